// File: rtl/pfb_mac_drain.sv
// rtl/pfb_mac_drain.sv - PFB MAC cascade drain: valid tracking, round/saturate, channel tag, FWFT output FIFO
// Drives the shared cascade ce as backpressure so results are never dropped.
module pfb_mac_drain #(
  parameter int PIPE_LAT   = 19,
  parameter int IN_W       = 48,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int NUM_CHAN   = 64,
  parameter int FIFO_DEPTH = 8,
  localparam int CHAN_W    = $clog2(NUM_CHAN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              ce,
  input  logic [IN_W-1:0]   p_in,
  output logic [OUT_W-1:0]  m_data,
  output logic [CHAN_W-1:0] m_chan,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       sat_cnt,
  input  logic              sat_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = IN_W + 1;

  localparam logic signed [SUM_W-1:0] RND     = SUM_W'(64'd1 << (FRAC_SHIFT - 1));
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'd1 << (OUT_W - 1)) - 64'd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  logic                run;
  logic [PIPE_LAT-1:0] vld_sr;
  logic [CNT_W-1:0]    fifo_count;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CHAN_W-1:0]   chan_cnt;

  logic [OUT_W-1:0]    mem_data [FIFO_DEPTH];
  logic [CHAN_W-1:0]   mem_chan [FIFO_DEPTH];

  logic                fifo_empty;
  logic                push;
  logic                pop;

  logic signed [SUM_W-1:0] p_ext;
  logic signed [SUM_W-1:0] p_sum;
  logic signed [SUM_W-1:0] p_shr;
  logic [OUT_W-1:0]        res;
  logic                    sat;

  // ce depends only on registers so the cascade enable has no path from m_ready or p_in
  assign ce         = run && (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign push       = ce && vld_sr[PIPE_LAT-1];
  assign pop        = m_valid && m_ready;

  // Round half-up at one extra bit of headroom, then clamp to the signed output range
  assign p_ext = {p_in[IN_W-1], p_in};
  assign p_sum = p_ext + RND;
  assign p_shr = p_sum >>> FRAC_SHIFT;

  always_comb begin
    res = p_shr[OUT_W-1:0];
    sat = 1'b0;
    if (p_shr > SAT_MAX) begin
      res = SAT_MAX[OUT_W-1:0];
      sat = 1'b1;
    end else if (p_shr < SAT_MIN) begin
      res = SAT_MIN[OUT_W-1:0];
      sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run    <= 1'b0;
      vld_sr <= '0;
    end else begin
      run <= 1'b1;
      if (ce) begin
        vld_sr <= {vld_sr[PIPE_LAT-2:0], s_valid};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      chan_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        chan_cnt <= chan_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= res;
      mem_chan[wr_ptr] <= chan_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (push && sat && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_empty ? '0 : mem_data[rd_ptr];
  assign m_chan  = fifo_empty ? '0 : mem_chan[rd_ptr];
  assign m_last  = !fifo_empty && (mem_chan[rd_ptr] == CHAN_W'(NUM_CHAN - 1));

endmodule

// File: tb/tb_pfb_mac_drain.sv
// tb/tb_pfb_mac_drain.sv - randomized bench for pfb_mac_drain against a queue-based model
module tb_pfb_mac_drain;

  localparam int PIPE_LAT   = 19;
  localparam int IN_W       = 48;
  localparam int OUT_W      = 16;
  localparam int FRAC_SHIFT = 15;
  localparam int NUM_CHAN   = 64;
  localparam int FIFO_DEPTH = 8;
  localparam int CW         = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            m_ready = 1'b0;
  logic            sat_clr = 1'b0;
  logic [IN_W-1:0] p_in = '0;
  logic            ce;
  logic [OUT_W-1:0] m_data;
  logic [CW-1:0]   m_chan;
  logic            m_last;
  logic            m_valid;
  logic [15:0]     sat_cnt;

  pfb_mac_drain #(
    .PIPE_LAT(PIPE_LAT), .IN_W(IN_W), .OUT_W(OUT_W),
    .FRAC_SHIFT(FRAC_SHIFT), .NUM_CHAN(NUM_CHAN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .ce(ce), .p_in(p_in),
    .m_data(m_data), .m_chan(m_chan), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  // env_t: one sample as it travels the MAC cascade; exp_t: one result owed on the stream
  typedef struct { bit v; longint pv; bit hl; int lit; } env_t;
  typedef struct { longint data; int chan; bit hl; int lit; } exp_t;

  env_t envq[$];
  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   run_m = 0;
  int   chan_m = 0;
  int   sat_m = 0;
  bit   first_after_rst = 0;
  bit   clr_on_cap = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic longint model_out(input longint p, output bit sat);
    longint r;
    longint hi;
    hi  = (longint'(1) <<< (OUT_W - 1)) - 1;
    r   = (p + (longint'(1) <<< (FRAC_SHIFT - 1))) >>> FRAC_SHIFT;
    sat = 1'b1;
    if (r > hi) return hi;
    if (r < -hi - 1) return -hi - 1;
    sat = 1'b0;
    return r;
  endfunction

  function automatic longint rand_p();
    logic [63:0] t;
    t = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: return longint'($urandom_range(0, 1 << 21)) - (1 << 20);
      1: return longint'($urandom_range(0, 32'hFFFF_FFFF)) - 64'sd2147483648;
      2: return longint'({{16{t[47]}}, t[47:0]});
      default: return (longint'($urandom_range(0, 200)) - 100) * 32768 + 16384;
    endcase
  endfunction

  // One clock: check outputs at the negedge, drive inputs, then predict the next posedge
  task automatic cycle(input bit sv, input bit mr, input bit sc,
                       input longint pv, input bit hl, input int lit);
    bit     ce_m, pop_m, cap, sat;
    exp_t   e;
    env_t   n;
    logic [63:0] junk;
    @(negedge clk);
    chk("ce", ce, longint'(run_m && expq.size() != FIFO_DEPTH));
    chk("m_valid", m_valid, longint'(expq.size() != 0));
    chk("sat_cnt", sat_cnt, sat_m);
    if (expq.size() != 0) begin
      chk("m_data", longint'($signed(m_data)), expq[0].data);
      chk("m_chan", m_chan, expq[0].chan);
      chk("m_last", m_last, longint'(expq[0].chan == NUM_CHAN - 1));
    end
    junk = {$urandom, $urandom};
    p_in = (envq.size() == PIPE_LAT) ? envq[0].pv[IN_W-1:0] : junk[IN_W-1:0];
    ce_m  = run_m && expq.size() != FIFO_DEPTH;
    pop_m = expq.size() != 0 && mr;
    cap   = ce_m && envq.size() == PIPE_LAT && envq[0].v;
    s_valid = sv;
    m_ready = mr;
    sat_clr = sc | (clr_on_cap && cap);
    if (pop_m) begin
      if (expq[0].hl) chk("lit_data", longint'($signed(m_data)), expq[0].lit);
      if (first_after_rst) begin
        chk("chan_after_rst", m_chan, 0);
        first_after_rst = 0;
      end
      void'(expq.pop_front());
    end
    sat = 0;
    if (cap) begin
      e.data = model_out(envq[0].pv, sat);
      e.chan = chan_m;
      e.hl   = envq[0].hl;
      e.lit  = envq[0].lit;
      expq.push_back(e);
      chan_m = (chan_m + 1) % NUM_CHAN;
    end
    if (sat_clr) sat_m = 0;
    else if (cap && sat && sat_m < 65535) sat_m++;
    if (ce_m) begin
      n.v = sv; n.pv = pv; n.hl = hl; n.lit = lit;
      envq.push_back(n);
      if (envq.size() > PIPE_LAT) void'(envq.pop_front());
    end
    run_m = 1;
  endtask

  task automatic flush(input int cycles);
    for (int i = 0; i < cycles; i++) cycle(0, 1, 0, rand_p(), 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_ce", ce, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_chan", m_chan, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    envq.delete();
    expq.delete();
    run_m = 0; chan_m = 0; sat_m = 0; first_after_rst = 1;
    s_valid = 0; m_ready = 0; sat_clr = 0;
    repeat (3) @(negedge clk);
    chk("rst_hold_ce", ce, 0);
    rst_n = 1'b1;
    run_m = 1;
  endtask

  longint rnd_in  [7] = '{64'sh4000, 64'sh3FFF, -64'sh4000, -64'sh4001, 64'sh18000, 64'sh14000, 64'sh13FFF};
  int     rnd_out [7] = '{1, 0, 0, -1, 3, 3, 2};

  initial begin
    int k;
    do_reset();

    // Throughput: full rate, one result per cycle, channel wrap at 64
    for (int i = 0; i < 70; i++) cycle(1, 1, 0, longint'(i) * 32768, 1, i);
    flush(PIPE_LAT + 4);

    // Rounding corners
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, rnd_in[i], 1, rnd_out[i]);
    flush(PIPE_LAT + 4);

    // Saturation both rails, then clear coinciding with a saturating push
    cycle(0, 1, 1, 0, 0, 0);
    cycle(1, 1, 0, 64'sd2147483648, 1, 32767);
    cycle(1, 1, 0, -64'sd2147483648 - 32768, 1, -32768);
    flush(PIPE_LAT + 4);
    chk("sat_cnt_two", sat_cnt, 2);
    clr_on_cap = 1;
    cycle(1, 1, 0, 64'sd4000000000, 1, 32767);
    flush(PIPE_LAT + 4);
    clr_on_cap = 0;
    chk("sat_cnt_clr", sat_cnt, 0);

    // Backpressure: stalled sink fills the FIFO and freezes the cascade
    for (int i = 0; i < 40; i++) cycle(1, 0, 0, rand_p(), 0, 0);
    chk("bp_ce_low", ce, 0);
    chk("bp_full", m_valid, 1);
    cycle(1, 1, 0, rand_p(), 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, rand_p(), 0, 0);
    flush(PIPE_LAT + 40);

    // Gaps and random stalls
    for (int i = 0; i < 1500; i++) begin
      bit sv, mr;
      sv = (i < 750) ? bit'(i % 2) : bit'($urandom_range(0, 1));
      mr = ((i / 50) % 3 == 2) ? bit'($urandom_range(0, 3) == 0) : bit'($urandom_range(0, 3) != 0);
      cycle(sv, mr, bit'($urandom_range(0, 199) == 0), rand_p(), 0, 0);
    end
    flush(PIPE_LAT + 40);

    // Reset mid-frame with five results buffered
    k = 0;
    while (expq.size() != 5 && k < 200) begin
      cycle(1, 0, 0, rand_p(), 0, 0);
      k++;
    end
    chk("fill_five", expq.size(), 5);
    do_reset();
    for (int i = 0; i < 30; i++) cycle(1, 1, 0, longint'(i + 5) * 32768, 1, i + 5);
    flush(PIPE_LAT + 10);
    chk("drained", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
